// File: rtl/cam_pkg.sv
// Camera-domain types and frame geometry shared by the byte assembler and the rotation stage.
package cam_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } cam_state_t;

  typedef logic [15:0] rgb565_t;

  localparam int CAM_H_ACTIVE = 320;
  localparam int CAM_V_ACTIVE = 240;

endpackage

// File: rtl/camera_pixel_assembler.sv
// Packs the camera's vsync/href byte stream into RGB565 pixels and checks each frame's geometry.
module camera_pixel_assembler
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = CAM_H_ACTIVE,
  parameter int V_ACTIVE = CAM_V_ACTIVE,
  parameter int CNT_W    = 9
) (
  input  logic             cam_clk_in,
  input  logic             rst_n_in,
  input  logic             vsync_in,
  input  logic             href_in,
  input  logic [7:0]       pixel_data_in,
  output logic             valid_pixel_out,
  output logic [15:0]      pixel_out,
  output logic             frame_done_out,
  output logic             frame_error_out,
  output logic [CNT_W-1:0] line_count_out
);

  localparam logic [CNT_W-1:0] H_TGT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_TGT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             vsync_p0, href_p0;
  logic             vsync_p1, href_p1;
  logic [7:0]       data_p0;
  logic [7:0]       hi_byte_p1;
  rgb565_t          pixel_p2;

  cam_state_t       state;
  logic             phase;
  logic             err;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;

  logic             vs_rise, vs_fall, hr_fall;
  logic             trunc, line_end, in_active;
  logic             take_hi, take_lo;
  logic             line_bad, line_sat;
  logic [CNT_W-1:0] line_nxt;
  logic             err_nxt;

  // Stage p0/p1: input registers and their one-cycle history for edge detection
  always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vsync_p0 <= 1'b0;
      href_p0  <= 1'b0;
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
    end else begin
      vsync_p0 <= vsync_in;
      href_p0  <= href_in;
      vsync_p1 <= vsync_p0;
      href_p1  <= href_p0;
    end
  end

  always_ff @(posedge cam_clk_in) begin
    data_p0 <= pixel_data_in;
  end

  always_comb begin
    vs_rise   = vsync_p0 & ~vsync_p1;
    vs_fall   = ~vsync_p0 & vsync_p1;
    hr_fall   = ~href_p0 & href_p1;
    in_active = (state == ACTIVE);
    // A vsync rise during href closes the line early; the byte in that cycle is dropped
    trunc     = vs_rise & href_p0;
    line_end  = hr_fall | trunc;
    take_hi   = in_active & ~vs_rise & href_p0 & ~phase;
    take_lo   = in_active & ~vs_rise & href_p0 & phase;
    line_bad  = (pix_cnt != H_TGT) | phase;
    line_sat  = line_end & (line_cnt == CNT_MAX);
    line_nxt  = line_end ? sat_inc(line_cnt) : line_cnt;
    err_nxt   = err | (line_end & line_bad) | line_sat | trunc;
  end

  always_ff @(posedge cam_clk_in) begin
    if (take_hi) begin
      hi_byte_p1 <= data_p0;
    end
  end

  // Stage p2: capture FSM with registered pixel, strobe and frame status outputs
  always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= SYNC;
      phase           <= 1'b0;
      err             <= 1'b0;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      pixel_p2        <= '0;
      valid_pixel_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      valid_pixel_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      case (state)
        SYNC, BLANK: begin
          if (vs_fall) begin
            state    <= ACTIVE;
            phase    <= 1'b0;
            err      <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_done_out  <= 1'b1;
            frame_error_out <= err_nxt | (line_nxt != V_TGT);
            err             <= err_nxt;
            line_cnt        <= line_nxt;
            pix_cnt         <= '0;
            phase           <= 1'b0;
            state           <= BLANK;
          end else if (line_end) begin
            err      <= err_nxt;
            line_cnt <= line_nxt;
            pix_cnt  <= '0;
            phase    <= 1'b0;
          end else if (take_lo) begin
            pixel_p2        <= {hi_byte_p1, data_p0};
            valid_pixel_out <= 1'b1;
            pix_cnt         <= sat_inc(pix_cnt);
            phase           <= 1'b0;
            if (pix_cnt == CNT_MAX) begin
              err <= 1'b1;
            end
          end else if (take_hi) begin
            phase <= 1'b1;
          end
        end
        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

  assign pixel_out      = pixel_p2;
  assign line_count_out = line_cnt;

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Randomized frame-level bench for camera_pixel_assembler with a per-line byte-pair reference model.
module tb_camera_pixel_assembler;

  localparam int H    = 6;
  localparam int V    = 5;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          href  = 1'b0;
  logic [7:0]    data  = 8'h00;
  logic          valid;
  logic [15:0]   pix;
  logic          done;
  logic          ferr;
  logic [CW-1:0] lines;

  camera_pixel_assembler #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .CNT_W   (CW)
  ) dut (
    .cam_clk_in     (clk),
    .rst_n_in       (rst_n),
    .vsync_in       (vsync),
    .href_in        (href),
    .pixel_data_in  (data),
    .valid_pixel_out(valid),
    .pixel_out      (pix),
    .frame_done_out (done),
    .frame_error_out(ferr),
    .line_count_out (lines)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] pix;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   frame_pix = 0;
  int   done_cnt = 0;
  int   done_lines = 0;
  int   last_valid_cyc = 0;
  logic done_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pixel is matched in order against the model queue
  always @(negedge clk) begin
    if (valid) begin
      frame_pix++;
      last_valid_cyc = cyc;
      check("pixel_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pixel_value", 32'(pix), 32'(e.pix));
        check("pixel_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done) begin
      done_cnt++;
      done_err   = ferr;
      done_lines = int'(lines);
      check("done_after_last_valid", 32'(last_valid_cyc < cyc), 32'd1);
    end
    if (valid || done) check("valid_done_exclusive", 32'(valid & done), 32'd0);
    if (ferr) check("ferr_only_with_done", 32'(done), 32'd1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
    end
  endtask

  // mode 0: normal line end, 1: vsync rises with href still high, 2: leave href high
  task automatic send_line(input int nbytes, input bit fixed, input bit capture, input int mode);
    logic [7:0] hi, b;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (fixed) b = (i % 2 == 0) ? 8'hAB : 8'hCD;
      else b = 8'($urandom_range(0, 255));
      href = 1'b1;
      data = b;
      if (i % 2 == 0) hi = b;
      else if (capture) exp_q.push_back('{pix: {hi, b}, cyc: cyc + 2});
    end
    if (mode == 1) begin
      @(negedge clk);
      vsync = 1'b1;
      data  = 8'($urandom_range(0, 255));
    end
    if (mode != 2) begin
      @(negedge clk);
      href = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int lens[$], input bit trunc, input bit fixed);
    int exp_pix, exp_lines, d0;
    bit exp_err;
    @(negedge clk);
    href  = 1'b0;
    vsync = 1'b1;
    idle(3);
    @(negedge clk);
    vsync = 1'b0;
    idle(2);
    frame_pix = 0;
    d0        = done_cnt;
    exp_err   = (lens.size() != V) || trunc;
    exp_lines = (lens.size() > CMAX) ? CMAX : lens.size();
    exp_pix   = 0;
    for (int i = 0; i < lens.size(); i++) begin
      bit last_trunc;
      last_trunc = trunc && (i == lens.size() - 1);
      if (lens[i] != 2 * H) exp_err = 1'b1;
      exp_pix += lens[i] / 2;
      send_line(lens[i], fixed, 1'b1, last_trunc ? 1 : 0);
      if (!last_trunc) idle(1);
    end
    if (!trunc) begin
      @(negedge clk);
      vsync = 1'b1;
    end
    for (int k = 0; k < 12 && done_cnt == d0; k++) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_error"}, 32'(done_err), 32'(exp_err));
    check({tag, "_lines"}, 32'(done_lines), 32'(exp_lines));
    check({tag, "_pixels"}, 32'(frame_pix), 32'(exp_pix));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  initial begin
    int lens[$];
    int d0;

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_pixel", 32'(pix), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_lines", 32'(lines), 32'd0);

    // Released with vsync low: bytes and the first vsync rise must be ignored
    rst_n = 1'b1;
    send_line(2 * H, 1'b0, 1'b0, 0);
    idle(1);
    send_line(2 * H, 1'b0, 1'b0, 0);
    idle(1);
    @(negedge clk);
    vsync = 1'b1;
    idle(8);
    check("startup_no_done", 32'(done_cnt), 32'd0);
    check("startup_no_pixels", 32'(frame_pix), 32'd0);

    lens = {};
    repeat (V) lens.push_back(2 * H);
    run_frame("nominal", lens, 1'b0, 1'b1);

    lens[1] = 2 * H - 1;
    run_frame("short_line", lens, 1'b0, 1'b0);

    lens = {};
    repeat (V - 1) lens.push_back(2 * H);
    run_frame("short_frame", lens, 1'b0, 1'b0);

    lens.push_back(2 * H);
    run_frame("recovered", lens, 1'b0, 1'b0);

    lens[V-1] = 4;
    run_frame("vsync_trunc", lens, 1'b1, 1'b0);

    lens[V-1] = 2 * H;
    lens[0]   = 2 * H + 1;
    run_frame("odd_long_line", lens, 1'b0, 1'b0);

    lens = {};
    repeat (17) lens.push_back(2 * H);
    lens[0] = 36;
    run_frame("saturate", lens, 1'b0, 1'b0);

    // Reset pulsed in the middle of the third line
    @(negedge clk);
    vsync = 1'b1;
    idle(3);
    @(negedge clk);
    vsync = 1'b0;
    idle(2);
    send_line(2 * H, 1'b0, 1'b1, 0);
    idle(1);
    send_line(2 * H, 1'b0, 1'b1, 0);
    idle(1);
    send_line(3, 1'b0, 1'b1, 2);
    @(negedge clk);
    #1;
    check("midframe_lines", 32'(lines), 32'd2);
    check("midframe_queue_empty", 32'(exp_q.size()), 32'd0);
    #1;
    rst_n     = 1'b0;
    frame_pix = 0;
    d0        = done_cnt;
    #1;
    check("async_reset_valid", 32'(valid), 32'd0);
    check("async_reset_pixel", 32'(pix), 32'd0);
    check("async_reset_lines", 32'(lines), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_line(2 * H - 3, 1'b0, 1'b0, 0);
    idle(1);
    send_line(2 * H, 1'b0, 1'b0, 0);
    idle(1);
    @(negedge clk);
    vsync = 1'b1;
    idle(8);
    check("post_reset_no_done", 32'(done_cnt - d0), 32'd0);
    check("post_reset_no_pixels", 32'(frame_pix), 32'd0);

    lens = {};
    repeat (V) lens.push_back(2 * H);
    run_frame("resumed", lens, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/camera_pixel_assembler.md
Name: camera_pixel_assembler

Overview:
Upstream neighbour of the rotation/address stage. Converts the camera's 8-bit parallel byte stream (vsync/href/data, sampled on the pixel clock) into 16-bit RGB565 pixels with a one-cycle valid strobe and a one-cycle end-of-frame pulse. Outputs drive the rotation stage's pixel, valid and frame-done inputs directly. The block also checks frame geometry (pixels per line, lines per frame) and flags malformed frames.

Parameters:
H_ACTIVE, 320, pixels per camera line (byte pairs per href-high period)
V_ACTIVE, 240, lines per frame
CNT_W, 9, width of pixel/line counters (must hold max(H_ACTIVE, V_ACTIVE))

Ports:
cam_clk_in  input  1  camera pixel clock; all logic on posedge
rst_n_in  input  1  asynchronous active-low reset
vsync_in  input  1  camera vsync, already synchronous to cam_clk_in; high = vertical blank
href_in  input  1  camera line-valid; high while bytes of the current line are on pixel_data_in
pixel_data_in  input  8  camera byte
valid_pixel_out  output  1  one-cycle strobe: pixel_out holds a new pixel
pixel_out  output  16  assembled pixel {first byte, second byte}
frame_done_out  output  1  one-cycle pulse at end of each captured frame
frame_error_out  output  1  valid with frame_done_out; 1 = geometry mismatch in that frame
line_count_out  output  CNT_W  lines completed in the current frame

Behaviour:
- Reset is asynchronous and active-low. One clock, cam_clk_in. While rst_n_in = 0, all outputs are 0, the FSM is in SYNC and the byte phase is 0.
- Inputs are registered once (vsync_q, href_q, data_q). Edges are detected from current vs previous registered values.
- SYNC state: bytes are ignored. On a vsync_q falling edge -> ACTIVE, with pixel/line counters cleared. This guarantees that a partial first frame after reset is never emitted.
- ACTIVE state, per cycle with href_q = 1:
  - Phase 0: latch data_q as the high byte; phase <- 1.
  - Phase 1: pixel_out <= {high byte, data_q}; valid_pixel_out <= 1 on the next edge (1 cycle after the second byte is registered); pix_cnt increments; phase <- 0.
- href_q falling edge in ACTIVE:
  - line_count_out increments.
  - If pix_cnt != H_ACTIVE, or phase = 1 (odd byte count, trailing byte dropped and never emitted), set err.
  - pix_cnt and phase clear.
- vsync_q rising edge in ACTIVE:
  - frame_done_out = 1 for exactly one cycle.
  - frame_error_out = err OR (line_count_out != V_ACTIVE), registered alongside frame_done_out.
  - State -> BLANK.
- BLANK state: bytes are ignored. On a vsync_q falling edge -> ACTIVE, with err, line and pixel counters cleared.
- Simultaneous events:
  - If a vsync rising edge occurs while href_q = 1, the line is truncated: the href-fall checks are applied in the same cycle, and frame_done_out fires with frame_error_out = 1.
  - If the last pixel's valid and frame_done would coincide, valid_pixel_out is emitted first; frame_done_out is never earlier than the last valid_pixel_out.
- valid_pixel_out and frame_done_out are never high in the same cycle.
- Counter saturation: pix_cnt and line count saturate at all-ones (no wrap), and err is set when they saturate.
- valid_pixel_out is held at 0 in SYNC and BLANK.
- frame_error_out is held 0 except in the frame_done_out cycle.
- Reset asserted mid-frame returns immediately to SYNC. The next emitted frame begins only after a full vsync high->low sequence.

Decomposition:
- Package cam_pkg:
  - state enum {SYNC, ACTIVE, BLANK}
  - RGB565 pixel typedef (16 bits)
  - localparams CAM_H_ACTIVE = 320 and CAM_V_ACTIVE = 240, shared with the rotation stage
- No sub-module required. An optional small edge_detect helper may be shared with other camera-clock blocks.

Test Plan:
- Reset release with vsync already low and href toggling: no valid_pixel_out until a vsync high->low; no frame_done_out on the first vsync rise.
- Nominal frame, 240 lines x 640 bytes, bytes 0xAB,0xCD repeated:
  - 76800 valid_pixel_out pulses, each pixel_out = 0xABCD, each 1 cycle after the second byte.
  - One frame_done_out, frame_error_out = 0, line_count_out = 240 at done.
- One line carries 639 bytes: trailing byte not emitted; 76799 pixels; frame_error_out = 1 in the frame_done cycle.
- Frame with 239 lines: frame_error_out = 1. The following correct frame reports frame_error_out = 0 (err cleared on BLANK->ACTIVE).
- Vsync rises while href is high, mid-line: frame_done_out pulses with frame_error_out = 1. The final valid_pixel_out precedes frame_done_out, and the two are never in the same cycle.
- rst_n_in pulsed low mid-line:
  - Outputs go 0 asynchronously, within the same cycle.
  - The remainder of the frame produces no pixels.
  - Capture resumes only after the next full vsync.
